// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
//   state_t    : sequencer states
//   mem_req_t  : one master transaction {we, addr, wdata} at the default 8/8 widths
//   N_PORTS    : number of masters served
//   RST_LAST   : round-robin pointer value after reset (port 0 wins the first tie)
package mem_arb_pkg;

   localparam int   N_PORTS    = 2;
   localparam logic RST_LAST   = 1'b1;
   localparam int   DEF_ADDR_W = 8;
   localparam int   DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant, purely combinational.
//   i_req    : {req1, req0}
//   i_last   : port that owned the previous completed transaction
//   o_gnt_id : winning port (meaningful only while o_valid=1)
//   o_valid  : at least one request present
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_gnt_id,
   output logic       o_valid
);

   always_comb begin
      o_valid  = |i_req;
      o_gnt_id = 1'b0;
      // On a tie the port that did not go last wins; otherwise the lone requester.
      if (i_req == 2'b11) begin
         o_gnt_id = ~i_last;
      end else begin
         o_gnt_id = i_req[1];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer letting two req/ack masters share one
// single-port RAM, one transaction in flight at a time.
//   i_clk, i_rst                   : clock, async active-high reset
//   i_req*/i_we*/i_addr*/i_wdata*  : master requests (level req, fields latched at grant)
//   o_ack*/o_rdata*                : one-cycle completion pulse, read data valid with ack
//   o_busy, o_gnt_id               : sequencer activity, owner of current/last transaction
//   o_ram_*/i_ram_data_out         : RAM port
//
// state    | meaning
// S_IDLE   | waiting for a request; grant and latch the winner on the edge
// S_ACCESS | RAM address/data driven; write strobes one cycle, read waits READ_LAT cycles
// S_RESP   | ack pulse to the winner; round-robin pointer moves to the winner
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req0,
   input  logic              i_we0,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [DATA_W-1:0] i_wdata0,
   output logic              o_ack0,
   output logic [DATA_W-1:0] o_rdata0,
   input  logic              i_req1,
   input  logic              i_we1,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic              o_ack1,
   output logic [DATA_W-1:0] o_rdata1,
   output logic              o_busy,
   output logic              o_gnt_id,
   output logic              o_ram_wr_en,
   output logic [ADDR_W-1:0] o_ram_address,
   output logic [DATA_W-1:0] o_ram_data_in,
   input  logic [DATA_W-1:0] i_ram_data_out
);

   localparam int             CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

   state_t            r_state;
   logic              r_last;
   logic              r_we;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_gnt_id;
   logic              w_gnt_valid;
   logic              w_win_we;
   logic [ADDR_W-1:0] w_win_addr;
   logic [DATA_W-1:0] w_win_wdata;

   rr_arb2 u_rr_arb2 (
      .i_req    ({i_req1, i_req0}),
      .i_last   (r_last),
      .o_gnt_id (w_gnt_id),
      .o_valid  (w_gnt_valid)
   );

   always_comb begin
      w_win_we    = i_we0;
      w_win_addr  = i_addr0;
      w_win_wdata = i_wdata0;
      if (w_gnt_id) begin
         w_win_we    = i_we1;
         w_win_addr  = i_addr1;
         w_win_wdata = i_wdata1;
      end
   end

   // The RAM address/data output registers double as the latched request,
   // so they naturally hold their last values outside S_ACCESS.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_last        <= RST_LAST;
         r_we          <= 1'b0;
         r_cnt         <= '0;
         o_ack0        <= 1'b0;
         o_ack1        <= 1'b0;
         o_rdata0      <= '0;
         o_rdata1      <= '0;
         o_busy        <= 1'b0;
         o_gnt_id      <= 1'b0;
         o_ram_wr_en   <= 1'b0;
         o_ram_address <= '0;
         o_ram_data_in <= '0;
      end else begin
         o_ack0 <= 1'b0;
         o_ack1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_gnt_valid) begin
                  r_state       <= S_ACCESS;
                  o_busy        <= 1'b1;
                  o_gnt_id      <= w_gnt_id;
                  r_we          <= w_win_we;
                  r_cnt         <= CNT_LOAD;
                  o_ram_address <= w_win_addr;
                  o_ram_data_in <= w_win_wdata;
                  o_ram_wr_en   <= w_win_we;
               end
            end
            S_ACCESS: begin
               if (r_we || (r_cnt == '0)) begin
                  o_ram_wr_en <= 1'b0;
                  r_state     <= S_RESP;
                  if (o_gnt_id) begin
                     o_ack1 <= 1'b1;
                     if (!r_we) o_rdata1 <= i_ram_data_out;
                  end else begin
                     o_ack0 <= 1'b1;
                     if (!r_we) o_rdata0 <= i_ram_data_out;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RESP: begin
               r_last  <= o_gnt_id;
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               o_busy      <= 1'b0;
               o_ram_wr_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // main DUT (READ_LAT=1)
   logic       req0 = 0, we0 = 0, req1 = 0, we1 = 0;
   logic [7:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
   logic       ack0, ack1, busy, gnt, ram_we;
   logic [7:0] rdata0, rdata1, ram_addr, ram_din, ram_dout;

   // second DUT (READ_LAT=2)
   logic       b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
   logic [7:0] b_addr0 = 0, b_wdata0 = 0, b_addr1 = 0, b_wdata1 = 0;
   logic       b_ack0, b_ack1, b_busy, b_gnt, b_ram_we;
   logic [7:0] b_rdata0, b_rdata1, b_ram_addr, b_ram_din, b_ram_dout;

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(1)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
      .o_ack0(ack0), .o_rdata0(rdata0),
      .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
      .o_ack1(ack1), .o_rdata1(rdata1),
      .o_busy(busy), .o_gnt_id(gnt),
      .o_ram_wr_en(ram_we), .o_ram_address(ram_addr), .o_ram_data_in(ram_din),
      .i_ram_data_out(ram_dout)
   );

   mem_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LAT(2)) dut2 (
      .i_clk(clk), .i_rst(rst),
      .i_req0(b_req0), .i_we0(b_we0), .i_addr0(b_addr0), .i_wdata0(b_wdata0),
      .o_ack0(b_ack0), .o_rdata0(b_rdata0),
      .i_req1(b_req1), .i_we1(b_we1), .i_addr1(b_addr1), .i_wdata1(b_wdata1),
      .o_ack1(b_ack1), .o_rdata1(b_rdata1),
      .o_busy(b_busy), .o_gnt_id(b_gnt),
      .o_ram_wr_en(b_ram_we), .o_ram_address(b_ram_addr), .o_ram_data_in(b_ram_din),
      .i_ram_data_out(b_ram_dout)
   );

   // RAMs: async read for READ_LAT=1, one registered read stage for READ_LAT=2
   logic [7:0] ram  [256];
   logic [7:0] ram2 [256];
   logic [7:0] model_mem [256];
   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]       = 8'(i) ^ 8'h5A;
         ram2[i]      = 8'(i) ^ 8'h5A;
         model_mem[i] = 8'(i) ^ 8'h5A;
      end
   end
   always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;
   assign ram_dout = ram[ram_addr];
   always @(posedge clk) begin
      if (b_ram_we) ram2[b_ram_addr] <= b_ram_din;
      b_ram_dout <= ram2[b_ram_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // One transaction at a time: a request visible in a free cycle c is granted,
   // drives the RAM in cycle c+1, is acked in cycle c+1+lat, and the arbiter is
   // free again the cycle after the ack.
   localparam int LAT = 1;
   bit         m_act  = 0;
   int         m_start, m_ack, m_free = 0, m_port;
   logic       m_we;
   logic [7:0] m_addr, m_wdata;
   logic       m_last = 1'b1;
   logic       exp_gnt = 0;
   logic [7:0] exp_addr = 0, exp_din = 0;
   logic [7:0] exp_rd [2];
   int         ack_cnt [2];
   int         wr_cnt = 0, wr_cyc = -1;
   logic [7:0] wr_addr = 0, wr_data = 0;

   always @(negedge clk) begin
      if (rst) begin
         m_act = 0; m_free = 0; m_last = 1'b1; exp_gnt = 0;
         exp_addr = 0; exp_din = 0; exp_rd[0] = 0; exp_rd[1] = 0;
      end else begin
         if (m_act && cyc == m_start) begin
            exp_gnt = m_port[0]; exp_addr = m_addr; exp_din = m_wdata;
         end
         if (m_act && cyc == m_ack) begin
            if (m_we) model_mem[m_addr] = m_wdata;
            else      exp_rd[m_port]    = model_mem[m_addr];
         end
         chk("ack0",        32'(ack0),   32'(m_act && cyc == m_ack && m_port == 0));
         chk("ack1",        32'(ack1),   32'(m_act && cyc == m_ack && m_port == 1));
         chk("ram_wr_en",   32'(ram_we), 32'(m_act && cyc == m_start && m_we));
         chk("busy",        32'(busy),   32'(m_act && cyc >= m_start && cyc <= m_ack));
         chk("gnt_id",      32'(gnt),    32'(exp_gnt));
         chk("ram_address", 32'(ram_addr), 32'(exp_addr));
         chk("ram_data_in", 32'(ram_din),  32'(exp_din));
         chk("rdata0",      32'(rdata0),   32'(exp_rd[0]));
         chk("rdata1",      32'(rdata1),   32'(exp_rd[1]));
         if (ack0) ack_cnt[0]++;
         if (ack1) ack_cnt[1]++;
         if (ram_we) begin wr_cnt++; wr_cyc = cyc; wr_addr = ram_addr; wr_data = ram_din; end
         if (m_act && cyc == m_ack) begin
            m_last = m_port[0]; m_act = 0; m_free = m_ack + 1;
         end
         if (!m_act && cyc >= m_free && (req0 || req1)) begin
            if (req0 && req1) m_port = m_last ? 0 : 1;
            else              m_port = req1 ? 1 : 0;
            m_we    = m_port == 1 ? we1    : we0;
            m_addr  = m_port == 1 ? addr1  : addr0;
            m_wdata = m_port == 1 ? wdata1 : wdata0;
            m_start = cyc + 1;
            m_ack   = m_we ? cyc + 2 : cyc + 1 + LAT;
            m_act   = 1;
         end
      end
   end

   // call at posedge+1; returns at posedge+1 of the cycle after the ack with req dropped
   task automatic do_txn(input int p, input logic we, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int ackc);
      ackc = -1;
      rd   = 8'h00;
      if (p == 0) begin we0 = we; addr0 = a; wdata0 = d; req0 = 1; end
      else        begin we1 = we; addr1 = a; wdata1 = d; req1 = 1; end
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if ((p == 0 && ack0) || (p == 1 && ack1)) begin
            ackc = cyc;
            rd   = (p == 0) ? rdata0 : rdata1;
            break;
         end
      end
      if (ackc < 0) begin
         n_checks++; n_fail++;
         $display("FAIL ack_timeout: port %0d got no ack, required one within 60 cycles", p);
      end
      @(posedge clk); #1;
      if (p == 0) req0 = 0; else req1 = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1;
      @(negedge clk);
      @(posedge clk); #1 rst = 0;
   endtask

   task automatic master(input int p, input int n);
      mem_req_t   t;
      logic [7:0] rd;
      int         ac, gap;
      for (int i = 0; i < n; i++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) begin @(posedge clk); #1; end
         t.we    = 1'($urandom_range(0, 1));
         t.addr  = 8'($urandom_range(0, 15));
         t.wdata = 8'($urandom);
         do_txn(p, t.we, t.addr, t.wdata, rd, ac);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd, rdb;
      int c0, w0, a0, a1, ac, snap1;
      int acks0 [3];
      int acks1 [3];
      exp_rd[0] = 0; exp_rd[1] = 0; ack_cnt[0] = 0; ack_cnt[1] = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack0", 32'(ack0), 0);
      chk("rst_ack1", 32'(ack1), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_wr_en", 32'(ram_we), 0);
      chk("rst_address", 32'(ram_addr), 0);
      chk("rst_rdata1", 32'(rdata1), 0);
      rst = 0;

      // port 0 write then port 1 read-back
      @(posedge clk); #1;
      c0 = cyc; w0 = wr_cnt;
      do_txn(0, 1'b1, 8'h0A, 8'hAB, rd, ac);
      chk("wr_ack_cycle", 32'(ac), 32'(c0 + 2));
      chk("wr_strobe_count", 32'(wr_cnt), 32'(w0 + 1));
      chk("wr_strobe_cycle", 32'(wr_cyc), 32'(c0 + 1));
      chk("wr_strobe_addr", 32'(wr_addr), 32'h0A);
      chk("wr_strobe_data", 32'(wr_data), 32'hAB);
      c0 = cyc;
      do_txn(1, 1'b0, 8'h0A, 8'h00, rd, ac);
      chk("rd_ack_cycle", 32'(ac), 32'(c0 + 2));
      chk("rd_data_0A", 32'(rd), 32'hAB);

      // simultaneous requests right after reset: port 0 first
      do_reset();
      c0 = cyc;
      fork
         begin logic [7:0] r; do_txn(0, 1'b1, 8'h10, 8'h11, r, a0); end
         begin logic [7:0] r; do_txn(1, 1'b1, 8'h20, 8'h22, r, a1); end
      join
      chk("tie_ack0_cycle", 32'(a0), 32'(c0 + 2));
      chk("tie_ack1_cycle", 32'(a1), 32'(c0 + 5));
      do_txn(0, 1'b0, 8'h10, 8'h00, rd, ac);
      chk("readback_10", 32'(rd), 32'h11);
      do_txn(1, 1'b0, 8'h20, 8'h00, rd, ac);
      chk("readback_20", 32'(rd), 32'h22);

      // both requests held for six transactions: strict alternation, 3-cycle spacing
      c0 = cyc;
      fork
         for (int i = 0; i < 3; i++) begin
            logic [7:0] r; int a;
            do_txn(0, 1'b0, 8'(8'h30 + 2 * i), 8'h00, r, a); acks0[i] = a;
         end
         for (int i = 0; i < 3; i++) begin
            logic [7:0] r; int a;
            do_txn(1, 1'b0, 8'(8'h31 + 2 * i), 8'h00, r, a); acks1[i] = a;
         end
      join
      for (int i = 0; i < 3; i++) begin
         chk("rr_ack0_cycle", 32'(acks0[i]), 32'(c0 + 2 + 6 * i));
         chk("rr_ack1_cycle", 32'(acks1[i]), 32'(c0 + 5 + 6 * i));
      end

      // only port 0 active: three back-to-back reads, port 1 untouched
      snap1 = ack_cnt[1];
      c0 = cyc;
      do_txn(0, 1'b0, 8'h00, 8'h00, rd, a0);
      chk("solo_rd_00", 32'(rd), 32'h5A);
      do_txn(0, 1'b0, 8'h01, 8'h00, rd, a1);
      chk("solo_rd_01", 32'(rd), 32'h5B);
      chk("solo_spacing", 32'(a1 - a0), 3);
      do_txn(0, 1'b0, 8'h02, 8'h00, rd, ac);
      chk("solo_rd_02", 32'(rd), 32'h58);
      chk("solo_ack1_count", 32'(ack_cnt[1]), 32'(snap1));
      chk("solo_rdata1_hold", 32'(rdata1), 32'h6F);

      // reset in the middle of a write access
      @(posedge clk); #1;
      we0 = 1; addr0 = 8'hFF; wdata0 = 8'h77; req0 = 1;
      ac = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (ram_we) begin ac = cyc; break; end
      end
      chk("abort_reached_access", 32'(ac >= 0), 1);
      #1 rst = 1; req0 = 0;
      #1;
      chk("abort_wr_en", 32'(ram_we), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ack0", 32'(ack0), 0);
      @(negedge clk);
      @(posedge clk); #1 rst = 0;
      c0 = cyc;
      do_txn(0, 1'b0, 8'h03, 8'h00, rd, ac);
      chk("post_abort_ack_cycle", 32'(ac), 32'(c0 + 2));
      chk("post_abort_rd_03", 32'(rd), 32'h59);

      // READ_LAT=2 instance
      @(posedge clk); #1;
      c0 = cyc; ac = -1;
      b_we0 = 1; b_addr0 = 8'h05; b_wdata0 = 8'h5A; b_req0 = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (b_ack0) begin ac = cyc; break; end
      end
      @(posedge clk); #1 b_req0 = 0;
      chk("lat2_wr_ack_cycle", 32'(ac), 32'(c0 + 2));
      c0 = cyc; ac = -1; rdb = 8'h00;
      b_we0 = 0; b_req0 = 1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (b_ack0) begin ac = cyc; rdb = b_rdata0; break; end
      end
      @(posedge clk); #1 b_req0 = 0;
      chk("lat2_rd_ack_cycle", 32'(ac), 32'(c0 + 3));
      chk("lat2_rd_data", 32'(rdb), 32'h5A);

      // randomized traffic from both masters against the model
      fork
         master(0, 40);
         master(1, 40);
      join
      repeat (4) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of memoria_ram (single-port, ADDR_W address, DATA_W data, synchronous write on clk).
- Lets two masters share the one RAM port, e.g. the Ahmes CPU on port 0 and a program loader/debug master on port 1.
- Each master uses a req/ack handshake.
- Arbitration is round-robin; one RAM transaction is in flight at a time.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
READ_LAT, 1, cycles from ram_address valid to ram_data_out valid (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req0  in  1  port 0 request (level)
we0  in  1  port 0 write (1) / read (0)
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 completion pulse
rdata0  out  DATA_W  port 0 read data, valid while ack0=1
req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1
busy  out  1  high while state != S_IDLE
gnt_id  out  1  port owning the current/last transaction
ram_wr_en  out  1  to memoria_ram wr_en
ram_address  out  ADDR_W  to memoria_ram address
ram_data_in  out  DATA_W  to memoria_ram data_in
ram_data_out  in  DATA_W  from memoria_ram data_out

Behaviour:
- Reset values (async, immediate): state=S_IDLE; ack0=ack1=0; rdata0=rdata1=0; busy=0; gnt_id=0; ram_wr_en=0; ram_address=0; ram_data_in=0; rr pointer last=1, so port 0 wins first.
- FSM states:
  - S_IDLE: if any req, choose winner, latch {we, addr, wdata} and gnt_id, then go to S_ACCESS. Otherwise stay.
  - S_ACCESS: ram_address and ram_data_in driven from latched registers.
    - Write: ram_wr_en=1 for exactly this one cycle, then go to S_RESP.
    - Read: ram_wr_en=0; stay READ_LAT cycles (down-counter). At the final cycle's edge, capture ram_data_out into the winner's rdata register, then go to S_RESP.
  - S_RESP: ack of the winner =1 for exactly one cycle. Set last=gnt_id. Go to S_IDLE.
- Winner selection: only one req → that port. Both req → port != last.
- Latency (READ_LAT=1): req seen in IDLE cycle 0 → ack in cycle 2 for both reads and writes. General read: ack in cycle 1+READ_LAT. Minimum spacing between transactions is 3 cycles (READ_LAT=1).
- Handshake:
  - Transfer completes at the rising edge where req&ack=1. The master updates or drops req at that edge.
  - A req still high in the following IDLE cycle is a new transaction.
  - Master holds we/addr/wdata stable only until the IDLE latch edge; later changes are ignored.
- rdata of the non-winning port holds its previous value. rdata of a write winner is unchanged.
- ram_address/ram_data_in hold their last values outside S_ACCESS. ram_wr_en=0 in every state except a write S_ACCESS.
- Never two acks in one cycle. ack never asserts without a prior req.
- req dropped by the loser before being served: no transaction, pointer unchanged.
- Reset mid-operation: FSM returns to S_IDLE asynchronously and ram_wr_en falls immediately. A write in S_ACCESS may or may not have committed to the RAM. No ack is issued for the aborted transaction.
- Addresses wrap naturally at 2^ADDR_W (no range checking).

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {S_IDLE, S_ACCESS, S_RESP}
  - mem_req_t struct {we, addr[ADDR_W], wdata[DATA_W]}
  - localparams N_PORTS=2, RST_LAST=1
- One sub-module, rr_arb2: combinational grant from {req1,req0} and last. Output gnt_id plus a valid flag.
- FSM, latency counter and datapath stay in mem_arbiter.

Test Plan:
- Port 0 write addr 0x0A data 0xAB (req0 at cycle 0) → ram_wr_en=1 only in cycle 1 with ram_address=0x0A and ram_data_in=0xAB; ack0 in cycle 2. Then port 1 read 0x0A → ack1 with rdata1=0xAB.
- After reset, req0 and req1 high in the same cycle (writes 0x10←0x11, 0x20←0x22) → port 0 acked first, port 1 next. Read-back returns 0x11 and 0x22.
- Both reqs held continuously for 6 transactions → grant order 0,1,0,1,0,1; ack spacing 3 cycles.
- Only req0 held for 3 back-to-back reads of 0x00/0x01/0x02 → three ack0 pulses; ack1 never asserts; rdata1 unchanged.
- rst asserted during S_ACCESS of a write → ram_wr_en, busy and acks go to 0 before the next edge. After release, a new req0 is served normally.
- READ_LAT=2 build, read 0x05 after writing 0x5A → ack in cycle 3, rdata=0x5A.
